// File: rtl/exunit_ldst_q_if.sv
`default_nettype none
// ============================================================================
// Module      : exunit_ldst_q_if
// Description : Bundle between the load/store reservation station, the store
//               buffer / data memory and the writeback ports of
//               exunit_ldst_q. The slave modport is the execution unit side.
//               Optional macro MISALIGN_TRAP_EN adds the misalign output.
// Revision    : 1.0 - initial release
// ============================================================================
interface exunit_ldst_q_if #(
    parameter int DATA_LEN    = 32,
    parameter int ADDR_LEN    = 32,
    parameter int RRF_SEL     = 6,
    parameter int SPECTAG_LEN = 5
) ();
    // issue side
    logic                    issue;
    logic                    ready;
    logic [DATA_LEN-1:0]     ex_src1;
    logic [DATA_LEN-1:0]     ex_src2;
    logic [DATA_LEN-1:0]     imm;
    logic                    dstval;
    logic [1:0]              size;
    logic                    sext;
    logic [SPECTAG_LEN-1:0]  spectag;
    logic                    specbit;
    logic [RRF_SEL-1:0]      rrftag;
    // branch recovery
    logic                    prmiss;
    logic [SPECTAG_LEN-1:0]  spectagfix;
    // store buffer
    logic                    fullsb;
    logic                    stfin;
    logic [ADDR_LEN-1:0]     storeaddr;
    logic [DATA_LEN-1:0]     storedata;
    logic [DATA_LEN/8-1:0]   storemask;
    // load path
    logic                    memoccupy_ld;
    logic [ADDR_LEN-1:0]     ldaddr;
    logic                    hitsb;
    logic [DATA_LEN-1:0]     lddatasb;
    logic [DATA_LEN-1:0]     lddatamem;
    // writeback
    logic [DATA_LEN-1:0]     result;
    logic                    rrf_we;
    logic                    rob_we;
    logic [RRF_SEL-1:0]      wrrftag;
    logic                    kill_speculative;
`ifdef MISALIGN_TRAP_EN
    logic                    misalign;
`endif

    modport slave (
        input  issue, ex_src1, ex_src2, imm, dstval, size, sext,
        input  spectag, specbit, rrftag, prmiss, spectagfix, fullsb,
        input  hitsb, lddatasb, lddatamem,
`ifdef MISALIGN_TRAP_EN
        output misalign,
`endif
        output ready, stfin, storeaddr, storedata, storemask,
        output memoccupy_ld, ldaddr, result, rrf_we, rob_we, wrrftag,
        output kill_speculative
    );

    modport master (
        output issue, ex_src1, ex_src2, imm, dstval, size, sext,
        output spectag, specbit, rrftag, prmiss, spectagfix, fullsb,
        output hitsb, lddatasb, lddatamem,
`ifdef MISALIGN_TRAP_EN
        input  misalign,
`endif
        input  ready, stfin, storeaddr, storedata, storemask,
        input  memoccupy_ld, ldaddr, result, rrf_we, rob_we, wrrftag,
        input  kill_speculative
    );
endinterface
`default_nettype wire

// File: rtl/exunit_ldst_q.sv
`default_nettype none
// ============================================================================
// Module      : exunit_ldst_q
// Description : Load/store execution unit with a QDEPTH-entry in-order issue
//               queue, byte/half/word accesses with sign/zero extension,
//               store byte masks and speculative-kill support.
//               Optional macro MISALIGN_TRAP_EN: misaligned accesses make no
//               memory request and complete with misalign=1.
// Revision    : 1.0 - initial release
// ============================================================================
module exunit_ldst_q #(
    parameter int DATA_LEN    = 32,
    parameter int ADDR_LEN    = 32,
    parameter int RRF_SEL     = 6,
    parameter int SPECTAG_LEN = 5,
    parameter int QDEPTH      = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    exunit_ldst_q_if.slave     bus
);
    localparam int c_NB = DATA_LEN / 8;
    localparam int c_CW = $clog2(QDEPTH + 1);
    localparam logic [c_CW-1:0] c_QD = c_CW'(QDEPTH);

    typedef struct packed {
        logic                   valid;
        logic                   isload;
        logic [ADDR_LEN-1:0]    addr;
        logic [DATA_LEN-1:0]    data;
        logic [1:0]             size;
        logic                   sext;
        logic [SPECTAG_LEN-1:0] spectag;
        logic                   specbit;
        logic [RRF_SEL-1:0]     rrftag;
    } entry_t;

    // queue storage: slot 0 is always the head, younger entries above it
    entry_t             r_q [QDEPTH];
    logic [c_CW-1:0]    r_count;

    // stage-2 latches
    logic                   r_s2_valid;
    logic                   r_s2_load;
    logic [RRF_SEL-1:0]     r_s2_rrftag;
    logic [SPECTAG_LEN-1:0] r_s2_spectag;
    logic                   r_s2_specbit;
    logic [1:0]             r_s2_size;
    logic                   r_s2_sext;
    logic [1:0]             r_s2_a;
    logic                   r_s2_hitsb;
    logic [DATA_LEN-1:0]    r_s2_sbdata;
`ifdef MISALIGN_TRAP_EN
    logic                   r_s2_mis;
`endif

    entry_t             w_q_kill [QDEPTH+1];
    entry_t             w_q_next [QDEPTH];
    entry_t             w_new;
    logic               w_ready;
    logic               w_issue_kill;
    logic               w_enq;
    logic               w_deq;
    logic               w_head_live;
    logic               w_head_fire;
    logic               w_head_mis;
    logic [1:0]         w_a_raw;
    logic [1:0]         w_a;
    logic [c_CW-1:0]    w_enq_idx;
    logic [DATA_LEN-1:0] w_word;
    logic [DATA_LEN-1:0] w_lane;

    assign w_ready      = (r_count < c_QD);
    assign w_issue_kill = bus.prmiss && bus.specbit && (|(bus.spectag & bus.spectagfix));

    // Fields of the incoming op; effective address wraps at ADDR_LEN bits
    always_comb begin
        w_new         = '0;
        w_new.valid   = 1'b1;
        w_new.isload  = bus.dstval;
        w_new.addr    = ADDR_LEN'(bus.ex_src1 + bus.imm);
        w_new.data    = bus.ex_src2;
        w_new.size    = bus.size;
        w_new.sext    = bus.sext;
        w_new.spectag = bus.spectag;
        w_new.specbit = bus.specbit;
        w_new.rrftag  = bus.rrftag;
    end

    // Apply this cycle's mispredict kill to every queued entry; the extra top
    // slot is the empty entry shifted in on dequeue
    always_comb begin
        for (int i = 0; i < QDEPTH; i++) begin
            w_q_kill[i] = r_q[i];
            if (bus.prmiss && r_q[i].specbit && (|(r_q[i].spectag & bus.spectagfix)))
                w_q_kill[i].valid = 1'b0;
        end
        w_q_kill[QDEPTH] = '0;
    end

    // Lane offset: misaligned halves/words fall back to the naturally aligned lane
    assign w_a_raw = r_q[0].addr[1:0];
    always_comb begin
        case (r_q[0].size)
            2'd0:    w_a = w_a_raw;
            2'd1:    w_a = {w_a_raw[1], 1'b0};
            default: w_a = 2'b00;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign w_head_mis = ((r_q[0].size == 2'd1) && w_a_raw[0]) ||
                        (r_q[0].size[1] && (w_a_raw != 2'b00));
`else
    assign w_head_mis = 1'b0;
`endif

    // A dead head always leaves; a live store waits for store-buffer room
    assign w_head_live = (r_count != '0) && w_q_kill[0].valid;
    assign w_deq       = (r_count != '0) &&
                         (!w_head_live || r_q[0].isload || w_head_mis || !bus.fullsb);
    assign w_head_fire = w_deq && w_head_live;
    assign w_enq       = bus.issue && w_ready && !w_issue_kill;
    assign w_enq_idx   = w_deq ? (r_count - c_CW'(1)) : r_count;

    // Next queue contents: kill, then shift on dequeue, then write the new op
    always_comb begin
        for (int i = 0; i < QDEPTH; i++) begin
            w_q_next[i] = w_deq ? w_q_kill[i+1] : w_q_kill[i];
            if (w_enq && (c_CW'(i) == w_enq_idx))
                w_q_next[i] = w_new;
        end
    end

    // Queue and occupancy registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++)
                r_q[i] <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < QDEPTH; i++)
                r_q[i] <= w_q_next[i];
            r_count <= r_count + c_CW'(w_enq) - c_CW'(w_deq);
        end
    end

    // Stage-2 capture of the op leaving the queue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid   <= 1'b0;
            r_s2_load    <= 1'b0;
            r_s2_rrftag  <= '0;
            r_s2_spectag <= '0;
            r_s2_specbit <= 1'b0;
            r_s2_size    <= 2'd0;
            r_s2_sext    <= 1'b0;
            r_s2_a       <= 2'd0;
            r_s2_hitsb   <= 1'b0;
            r_s2_sbdata  <= '0;
`ifdef MISALIGN_TRAP_EN
            r_s2_mis     <= 1'b0;
`endif
        end else if (w_head_fire) begin
            r_s2_valid   <= 1'b1;
            r_s2_load    <= r_q[0].isload;
            r_s2_rrftag  <= r_q[0].rrftag;
            r_s2_spectag <= r_q[0].spectag;
            r_s2_specbit <= r_q[0].specbit;
            r_s2_size    <= r_q[0].size;
            r_s2_sext    <= r_q[0].sext;
            r_s2_a       <= w_a;
            r_s2_hitsb   <= bus.hitsb;
            r_s2_sbdata  <= bus.lddatasb;
`ifdef MISALIGN_TRAP_EN
            r_s2_mis     <= w_head_mis;
`endif
        end else begin
            // specbit cleared so an idle stage 2 never raises kill_speculative
            r_s2_valid   <= 1'b0;
            r_s2_specbit <= 1'b0;
        end
    end

    // Load lane extraction from forwarded or memory word
    always_comb begin
        w_word = r_s2_hitsb ? r_s2_sbdata : bus.lddatamem;
        w_lane = w_word >> {r_s2_a, 3'b000};
        case (r_s2_size)
            2'd0:    bus.result = {{(DATA_LEN-8){r_s2_sext & w_lane[7]}}, w_lane[7:0]};
            2'd1:    bus.result = {{(DATA_LEN-16){r_s2_sext & w_lane[15]}}, w_lane[15:0]};
            default: bus.result = w_word;
        endcase
    end

    // Store data replication and byte enables for the head entry
    always_comb begin
        case (r_q[0].size)
            2'd0: begin
                bus.storedata = {c_NB{r_q[0].data[7:0]}};
                bus.storemask = c_NB'(1) << w_a;
            end
            2'd1: begin
                bus.storedata = {(c_NB/2){r_q[0].data[15:0]}};
                bus.storemask = c_NB'(3) << w_a;
            end
            default: begin
                bus.storedata = r_q[0].data;
                bus.storemask = '1;
            end
        endcase
    end

    assign bus.ready        = w_ready;
    assign bus.storeaddr    = {r_q[0].addr[ADDR_LEN-1:2], 2'b00};
    assign bus.ldaddr       = {r_q[0].addr[ADDR_LEN-1:2], 2'b00};
    assign bus.stfin        = w_head_live && !r_q[0].isload && !w_head_mis && !bus.fullsb;
    assign bus.memoccupy_ld = w_head_live && r_q[0].isload && !w_head_mis;
    assign bus.rob_we       = r_s2_valid;
    assign bus.wrrftag      = r_s2_rrftag;
    assign bus.kill_speculative = bus.prmiss && r_s2_specbit &&
                                  (|(r_s2_spectag & bus.spectagfix));
`ifdef MISALIGN_TRAP_EN
    assign bus.rrf_we       = r_s2_valid && r_s2_load && !r_s2_mis;
    assign bus.misalign     = r_s2_valid && r_s2_mis;
`else
    assign bus.rrf_we       = r_s2_valid && r_s2_load;
`endif

    // Flag an issue presented while the queue is full (the request is dropped)
    always @(posedge clk) begin
        if (!reset)
            assert (!(bus.issue && !w_ready))
                else $error("exunit_ldst_q: issue while queue full, request dropped");
    end
endmodule
`default_nettype wire
